// File: rtl/gemm_operand_feeder.sv
// Operand staging buffer for the 2x2 systolic array: stores A columns and B rows,
// then replays them for K steps with a one-cycle skew on lane 1.
module gemm_operand_feeder #(
  parameter int unsigned OP_WIDTH = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sel,
  input  logic [AW-1:0]         wr_addr,
  input  logic [2*OP_WIDTH-1:0] wr_data,
  input  logic [AW:0]           k_len,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [2*OP_WIDTH-1:0] new_a_column,
  output logic [1:0]            new_a_column_ena,
  output logic [2*OP_WIDTH-1:0] new_b_row,
  output logic [1:0]            new_b_row_ena
);

  localparam int unsigned DW = 2 * OP_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state;
  logic [AW:0]   k_q;
  logic [AW:0]   cnt;
  logic [DW-1:0] a_mem [DEPTH];
  logic [DW-1:0] b_mem [DEPTH];

  logic          wr_fire;
  logic [AW:0]   k_new;
  logic [AW:0]   step;
  logic [AW:0]   step_m1;
  logic [AW:0]   k_cur;
  logic          lane0_on;
  logic          lane1_on;
  logic [AW-1:0] idx0;
  logic [AW-1:0] idx1;
  logic [DW-1:0] a0, a1, b0, b1;
  logic [DW-1:0] issue_a, issue_b;
  logic [1:0]    issue_ena;

  assign wr_fire = wr_valid && wr_ready;
  assign k_new   = (32'(k_len) > DEPTH) ? (AW+1)'(DEPTH) : k_len;

  // Buffers are deliberately not reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire && (32'(wr_addr) < DEPTH)) begin
      if (wr_sel) b_mem[wr_addr] <= wr_data;
      else        a_mem[wr_addr] <= wr_data;
    end
  end

  // Step to issue at this edge: step 0 on start acceptance, otherwise cnt in RUN.
  // A same-cycle write is forwarded so the run sees it from step 0.
  always_comb begin
    step     = (state == RUN) ? cnt : '0;
    k_cur    = (state == RUN) ? k_q : k_new;
    step_m1  = step - (AW+1)'(1);
    lane0_on = (step < k_cur);
    lane1_on = (step != '0) && (step <= k_cur);
    idx0     = step[AW-1:0];
    idx1     = step_m1[AW-1:0];
    a0 = a_mem[idx0];
    a1 = a_mem[idx1];
    b0 = b_mem[idx0];
    b1 = b_mem[idx1];
    if (wr_fire && !wr_sel && wr_addr == idx0) a0 = wr_data;
    if (wr_fire && !wr_sel && wr_addr == idx1) a1 = wr_data;
    if (wr_fire &&  wr_sel && wr_addr == idx0) b0 = wr_data;
    if (wr_fire &&  wr_sel && wr_addr == idx1) b1 = wr_data;
    issue_a   = {lane1_on ? a1[DW-1:OP_WIDTH] : '0, lane0_on ? a0[OP_WIDTH-1:0] : '0};
    issue_b   = {lane1_on ? b1[DW-1:OP_WIDTH] : '0, lane0_on ? b0[OP_WIDTH-1:0] : '0};
    issue_ena = {lane1_on, lane0_on};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      k_q              <= '0;
      cnt              <= '0;
      wr_ready         <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      new_a_column     <= '0;
      new_a_column_ena <= '0;
      new_b_row        <= '0;
      new_b_row_ena    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            k_q <= k_new;
            if (k_new == '0) begin
              state            <= FIN;
              done             <= 1'b1;
              busy             <= 1'b0;
              wr_ready         <= 1'b1;
              new_a_column     <= '0;
              new_a_column_ena <= '0;
              new_b_row        <= '0;
              new_b_row_ena    <= '0;
            end else begin
              state            <= RUN;
              busy             <= 1'b1;
              wr_ready         <= 1'b0;
              cnt              <= (AW+1)'(1);
              new_a_column     <= issue_a;
              new_a_column_ena <= issue_ena;
              new_b_row        <= issue_b;
              new_b_row_ena    <= issue_ena;
            end
          end else begin
            state            <= IDLE;
            busy             <= 1'b0;
            wr_ready         <= 1'b1;
            new_a_column     <= '0;
            new_a_column_ena <= '0;
            new_b_row        <= '0;
            new_b_row_ena    <= '0;
          end
        end
        RUN: begin
          if (cnt > k_q) begin
            state            <= FIN;
            done             <= 1'b1;
            busy             <= 1'b0;
            wr_ready         <= 1'b1;
            new_a_column     <= '0;
            new_a_column_ena <= '0;
            new_b_row        <= '0;
            new_b_row_ena    <= '0;
          end else begin
            cnt              <= cnt + (AW+1)'(1);
            new_a_column     <= issue_a;
            new_a_column_ena <= issue_ena;
            new_b_row        <= issue_b;
            new_b_row_ena    <= issue_ena;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_operand_feeder.sv
// Self-checking bench for gemm_operand_feeder: randomized buffer contents and K,
// checked cycle by cycle against a skewed-replay reference model.
module tb_gemm_operand_feeder;

  localparam int OPW   = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic             wr_sel = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [2*OPW-1:0] wr_data = '0;
  logic [AW:0]      k_len = '0;
  logic             start = 1'b0;
  logic             busy;
  logic             done;
  logic [2*OPW-1:0] new_a_column;
  logic [1:0]       new_a_column_ena;
  logic [2*OPW-1:0] new_b_row;
  logic [1:0]       new_b_row_ena;

  int errors = 0;
  int checks = 0;

  logic [2*OPW-1:0] a_ref [DEPTH];
  logic [2*OPW-1:0] b_ref [DEPTH];

  gemm_operand_feeder #(.OP_WIDTH(OPW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .k_len(k_len),
    .start(start), .busy(busy), .done(done),
    .new_a_column(new_a_column), .new_a_column_ena(new_a_column_ena),
    .new_b_row(new_b_row), .new_b_row_ena(new_b_row_ena)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane i at step c carries entry (c - i) when that entry lies in [0, K).
  function automatic logic [2*OPW-1:0] exp_lanes(input bit is_b, input int c, input int kk);
    logic [2*OPW-1:0] r, e;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      if (c - i >= 0 && c - i < kk) begin
        e = is_b ? b_ref[c-i] : a_ref[c-i];
        r[i*OPW +: OPW] = e[i*OPW +: OPW];
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_ena(input int c, input int kk);
    logic [1:0] r;
    for (int i = 0; i < 2; i++) r[i] = (c - i >= 0) && (c - i < kk);
    return r;
  endfunction

  function automatic int clamp_k(input int kl);
    return (kl > DEPTH) ? DEPTH : kl;
  endfunction

  task automatic write_entry(input logic sel, input logic [AW-1:0] addr, input logic [2*OPW-1:0] data);
    wr_valid = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_idle: got %b want 1", wr_ready);
    end
    if (wr_ready === 1'b1 && int'(addr) < DEPTH) begin
      if (sel) b_ref[addr] = data;
      else     a_ref[addr] = data;
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic kick(input logic [AW:0] kl);
    k_len = kl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Checks steps 0..K (skipped for K=0) then the done cycle; returns in the done cycle.
  // If poke >= 0, start and a write are attempted during that step and must be ignored.
  task automatic check_stream(input int kk, input string name, input int poke);
    if (kk > 0) begin
      for (int c = 0; c <= kk; c++) begin
        if (c == poke) begin
          start = 1'b1; wr_valid = 1'b1; wr_sel = 1'($urandom);
          wr_addr = AW'($urandom); wr_data = 16'($urandom);
          checks++;
          if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s wr_ready_busy step %0d: got %b want 0", name, c, wr_ready);
          end
        end
        checks++;
        if (new_a_column !== exp_lanes(0, c, kk)) begin
          errors++;
          $display("FAIL %s a_col step %0d: got %h want %h", name, c, new_a_column, exp_lanes(0, c, kk));
        end
        checks++;
        if (new_b_row !== exp_lanes(1, c, kk)) begin
          errors++;
          $display("FAIL %s b_row step %0d: got %h want %h", name, c, new_b_row, exp_lanes(1, c, kk));
        end
        checks++;
        if (new_a_column_ena !== exp_ena(c, kk) || new_b_row_ena !== exp_ena(c, kk)) begin
          errors++;
          $display("FAIL %s ena step %0d: got a=%b b=%b want %b", name, c,
                   new_a_column_ena, new_b_row_ena, exp_ena(c, kk));
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_done step %0d: got busy=%b done=%b want 1/0", name, c, busy, done);
        end
        tick();
        start = 1'b0; wr_valid = 1'b0;
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1 ||
        new_a_column_ena !== 2'b00 || new_b_row_ena !== 2'b00) begin
      errors++;
      $display("FAIL %s fin: got done=%b busy=%b wr_ready=%b ena=%b/%b want 1/0/1/00/00",
               name, done, busy, wr_ready, new_a_column_ena, new_b_row_ena);
    end
  endtask

  task automatic finish_idle(input string name);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || new_a_column_ena !== 2'b00) begin
      errors++;
      $display("FAIL %s idle_after: got done=%b busy=%b ena=%b want 0/0/00", name, done, busy, new_a_column_ena);
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (new_a_column !== '0 || new_b_row !== '0 || new_a_column_ena !== 2'b00 ||
        new_b_row_ena !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: got a=%h b=%h ena=%b/%b busy=%b done=%b wr_ready=%b",
               new_a_column, new_b_row, new_a_column_ena, new_b_row_ena, busy, done, wr_ready);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    write_entry(1'b0, 2'd0, 16'h0301);
    write_entry(1'b0, 2'd1, 16'h0402);
    write_entry(1'b1, 2'd0, 16'h0605);
    write_entry(1'b1, 2'd1, 16'h0807);
    kick(3'd2);
    checks++;
    if (new_a_column !== 16'h0001 || new_b_row !== 16'h0005) begin
      errors++;
      $display("FAIL basic_first: got a=%h b=%h want 0001/0005", new_a_column, new_b_row);
    end
    check_stream(2, "basic", -1);
    finish_idle("basic");
  endtask

  task automatic test_write_start();
    wr_valid = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 16'hAA55;
    a_ref[0] = 16'hAA55;
    kick(3'd1);
    wr_valid = 1'b0;
    check_stream(1, "wr_start", -1);
    finish_idle("wr_start");
  endtask

  task automatic test_random();
    for (int w = 0; w < 2 * DEPTH; w++)
      write_entry(1'(w / DEPTH), AW'(w % DEPTH), 16'($urandom));
    for (int r = 0; r < 6; r++) begin
      int nw;
      logic [AW:0] kl;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        write_entry(1'($urandom), AW'($urandom), 16'($urandom));
      kl = (AW+1)'($urandom_range(1, 7));
      kick(kl);
      check_stream(clamp_k(int'(kl)), "random", -1);
      finish_idle("random");
    end
  endtask

  task automatic test_k0_clamp();
    kick(3'd0);
    check_stream(0, "k0", -1);
    finish_idle("k0");
    kick(3'd7);
    check_stream(clamp_k(7), "clamp", -1);
    finish_idle("clamp");
  endtask

  task automatic test_busy_lockout();
    kick(3'd3);
    check_stream(3, "lockout", 1);
    finish_idle("lockout");
    kick(3'd3);
    check_stream(3, "lockout_rerun", -1);
    finish_idle("lockout_rerun");
  endtask

  task automatic test_midrun_reset();
    kick(3'd3);
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (new_a_column !== '0 || new_b_row !== '0 || new_a_column_ena !== 2'b00 ||
        new_b_row_ena !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: got a=%h b=%h ena=%b/%b busy=%b done=%b wr_ready=%b",
               new_a_column, new_b_row, new_a_column_ena, new_b_row_ena, busy, done, wr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) reset_n = 1'b1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL midrun_no_done cycle %0d: got %b want 0", i, done);
      end
    end
    kick(3'd3);
    check_stream(3, "post_reset", -1);
    finish_idle("post_reset");
  endtask

  task automatic test_back_to_back();
    logic [AW:0] kl2;
    kick(3'd2);
    check_stream(2, "b2b_first", -1);
    kl2 = (AW+1)'($urandom_range(1, 4));
    kick(kl2);
    check_stream(clamp_k(int'(kl2)), "b2b_second", -1);
    finish_idle("b2b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_start();
    test_random();
    test_k0_clamp();
    test_busy_lockout();
    test_midrun_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
